// File: rtl/bp_me_stream_mux_to_wormhole_pkg.sv
// Shared types and helpers for the stream-to-wormhole converters.
package bp_me_stream_mux_to_wormhole_pkg;

   // Converter FSM: arbitrate/latch, stream header flits, pass data beats through.
   typedef enum logic [1:0] {
      e_idle,
      e_hdr,
      e_data
   } wh_state_e;

   // Number of flits needed to carry a header of hdr_bits bits.
   function automatic int wh_hdr_flits(input int hdr_bits, input int flit_width);
      return (hdr_bits + flit_width - 1) / flit_width;
   endfunction

endpackage

// File: rtl/bp_me_stream_mux_to_wormhole_if.sv
// Channel-side stream bundle plus the wormhole link, as seen by the mux.
interface bp_me_stream_mux_to_wormhole_if #(
   parameter int num_ch_p      = 2,
   parameter int flit_width_p  = 64,
   parameter int cord_width_p  = 8,
   parameter int cid_width_p   = 2,
   parameter int hdr_width_p   = 100,
   parameter int beats_width_p = 3
);
   logic [num_ch_p*hdr_width_p-1:0]   ch_hdr_i;
   logic [num_ch_p*cord_width_p-1:0]  ch_dst_cord_i;
   logic [num_ch_p*cid_width_p-1:0]   ch_dst_cid_i;
   logic [num_ch_p*beats_width_p-1:0] ch_beats_i;
   logic [num_ch_p*flit_width_p-1:0]  ch_data_i;
   logic [num_ch_p-1:0]               ch_v_i;
   logic [num_ch_p-1:0]               ch_ready_and_o;
   logic [flit_width_p-1:0]           link_data_o;
   logic                              link_v_o;
   logic                              link_ready_and_i;
   logic [num_ch_p-1:0]               grant_o;

   // The mux itself.
   modport slave (
      input  ch_hdr_i, ch_dst_cord_i, ch_dst_cid_i, ch_beats_i, ch_data_i, ch_v_i,
      input  link_ready_and_i,
      output ch_ready_and_o, link_data_o, link_v_o, grant_o
   );

   // Sources and the link consumer.
   modport master (
      output ch_hdr_i, ch_dst_cord_i, ch_dst_cid_i, ch_beats_i, ch_data_i, ch_v_i,
      output link_ready_and_i,
      input  ch_ready_and_o, link_data_o, link_v_o, grant_o
   );
endinterface

// File: rtl/bp_me_stream_mux_to_wormhole_rr.sv
// Round-robin arbiter; priority rotates to the channel after each consumed grant.
module bp_me_stream_mux_to_wormhole_rr #(
   parameter int num_ch_p = 2,
   localparam int idx_w_lp = (num_ch_p > 1) ? $clog2(num_ch_p) : 1
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic [num_ch_p-1:0] reqs_i,
   input  logic                yumi_i,
   output logic [num_ch_p-1:0] grants_o,
   output logic [idx_w_lp-1:0] grant_idx_o
);
   logic [idx_w_lp-1:0] ptr_r, ptr_n;
   logic                found;

   // Scan requests starting at the priority pointer; first requester wins.
   always_comb begin
      // NOTE: every output gets a default before the loop so no latch is inferred.
      grants_o    = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      for (int i = 0; i < num_ch_p; i++) begin
         if (!found && reqs_i[(int'(ptr_r) + i) % num_ch_p]) begin
            found                                     = 1'b1;
            grants_o[(int'(ptr_r) + i) % num_ch_p]    = 1'b1;
            grant_idx_o = idx_w_lp'((int'(ptr_r) + i) % num_ch_p);
         end
      end
      ptr_n = (grant_idx_o == idx_w_lp'(num_ch_p - 1)) ? '0 : grant_idx_o + idx_w_lp'(1);
   end

   // Advance priority past the winner only when the grant is consumed.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!reset_n_i)  ptr_r <= '0;
      else if (yumi_i) ptr_r <= ptr_n;
   end
endmodule

// File: rtl/bp_me_stream_mux_to_wormhole.sv
// Multi-channel stream to wormhole mux: packet-granular round-robin onto one link.
module bp_me_stream_mux_to_wormhole
   import bp_me_stream_mux_to_wormhole_pkg::*;
#(
   parameter int num_ch_p      = 2,
   parameter int flit_width_p  = 64,
   parameter int cord_width_p  = 8,
   parameter int len_width_p   = 4,
   parameter int cid_width_p   = 2,
   parameter int hdr_width_p   = 100,
   parameter int beats_width_p = 3
) (
   input  logic                            clk_i,
   input  logic                            reset_n_i,
   bp_me_stream_mux_to_wormhole_if.slave   bus
);
   localparam int hdr_bits_lp = cord_width_p + len_width_p + cid_width_p + hdr_width_p;
   localparam int h_lp        = wh_hdr_flits(hdr_bits_lp, flit_width_p);
   localparam int cnt_w_lp    = (h_lp > 1) ? $clog2(h_lp) : 1;
   localparam int idx_w_lp    = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;

   // Wormhole header, cord in the least-significant bits.
   typedef struct packed {
      logic [hdr_width_p-1:0]  hdr;
      logic [cid_width_p-1:0]  cid;
      logic [len_width_p-1:0]  len;
      logic [cord_width_p-1:0] cord;
   } wh_hdr_s;

   if (h_lp < 1) begin : g_bad_h
      $error("wormhole header must occupy at least one flit");
   end
   if ((h_lp - 1 + (1 << beats_width_p) - 1) >= (1 << len_width_p)) begin : g_bad_len
      $error("len_width_p too narrow for the largest packet");
   end

   wh_state_e                    state_r, state_n;
   logic [h_lp*flit_width_p-1:0] hdr_word_r, pick_word;
   wh_hdr_s                      pick_hdr;
   logic [beats_width_p-1:0]     beats_r, pick_beats;
   logic [num_ch_p-1:0]          grant_r, arb_grants, ch_ready;
   logic [idx_w_lp-1:0]          gidx_r, arb_idx;
   logic [cnt_w_lp-1:0]          cnt_r;
   logic [flit_width_p-1:0]      link_data;
   logic                         link_v, arb_yumi;

   assign arb_yumi = (state_r == e_idle) && (|bus.ch_v_i);

   bp_me_stream_mux_to_wormhole_rr #(.num_ch_p(num_ch_p)) arb (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .reqs_i      (bus.ch_v_i),
      .yumi_i      (arb_yumi),
      .grants_o    (arb_grants),
      .grant_idx_o (arb_idx)
   );

   // Build the zero-padded header word of the channel the arbiter is picking.
   always_comb begin
      pick_beats    = bus.ch_beats_i[arb_idx*beats_width_p +: beats_width_p];
      pick_hdr.hdr  = bus.ch_hdr_i[arb_idx*hdr_width_p +: hdr_width_p];
      pick_hdr.cid  = bus.ch_dst_cid_i[arb_idx*cid_width_p +: cid_width_p];
      pick_hdr.cord = bus.ch_dst_cord_i[arb_idx*cord_width_p +: cord_width_p];
      pick_hdr.len  = len_width_p'(h_lp - 1) + len_width_p'(pick_beats);
      pick_word     = '0;
      pick_word[hdr_bits_lp-1:0] = pick_hdr;
   end

   // Next state and link/channel outputs.
   always_comb begin
      state_n   = state_r;
      link_v    = 1'b0;
      link_data = '0;
      ch_ready  = '0;
      unique case (state_r)
         e_idle: if (arb_yumi) state_n = e_hdr;
         e_hdr: begin
            link_v    = 1'b1;
            link_data = hdr_word_r[cnt_r*flit_width_p +: flit_width_p];
            if (bus.link_ready_and_i && cnt_r == cnt_w_lp'(h_lp - 1)) begin
               if (beats_r == '0) begin
                  ch_ready = grant_r;
                  state_n  = e_idle;
               end else begin
                  state_n  = e_data;
               end
            end
         end
         e_data: begin
            link_v    = bus.ch_v_i[gidx_r];
            link_data = bus.ch_data_i[gidx_r*flit_width_p +: flit_width_p];
            ch_ready  = grant_r & {num_ch_p{bus.link_ready_and_i}};
            if (link_v && bus.link_ready_and_i && beats_r == beats_width_p'(1))
               state_n = e_idle;
         end
         default: state_n = e_idle;
      endcase
   end

   // FSM, packet bookkeeping and flit counter.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r <= e_idle;
         beats_r <= '0;
         grant_r <= '0;
         gidx_r  <= '0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_n;
         case (state_r)
            e_idle: if (arb_yumi) begin
               beats_r <= pick_beats;
               grant_r <= arb_grants;
               gidx_r  <= arb_idx;
               cnt_r   <= '0;
            end
            e_hdr:  if (bus.link_ready_and_i) cnt_r <= cnt_r + cnt_w_lp'(1);
            e_data: if (link_v && bus.link_ready_and_i) beats_r <= beats_r - beats_width_p'(1);
            default: ;
         endcase
      end
   end

   // Header word capture at the pick.
   always_ff @(posedge clk_i) begin
      // NOTE: pure datapath register, only read in e_hdr after a fresh capture, so it carries no reset.
      if (arb_yumi) hdr_word_r <= pick_word;
   end

   assign bus.link_v_o       = link_v;
   assign bus.link_data_o    = link_data;
   assign bus.ch_ready_and_o = ch_ready;
   assign bus.grant_o        = (state_r == e_idle) ? '0 : grant_r;
endmodule

// File: tb/tb_bp_me_stream_mux_to_wormhole.sv
// Directed bench for the 2-channel stream to wormhole mux (H = 2 header flits).
module tb_bp_me_stream_mux_to_wormhole;
   logic clk_i = 1'b0;
   logic reset_n_i;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk_i = ~clk_i;

   bp_me_stream_mux_to_wormhole_if bus ();

   bp_me_stream_mux_to_wormhole dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .bus       (bus)
   );

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference header word: {pad, hdr, cid, len, cord}, cord in the LSBs.
   function automatic logic [127:0] hw(input logic [99:0] h, input logic [1:0] cid,
                                       input logic [3:0] len, input logic [7:0] cord);
      return {14'b0, h, cid, len, cord};
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Check one cycle's outputs, then move to just after the next rising edge.
   task automatic cyc(input string tag, input bit v, input logic [63:0] d,
                      input logic [1:0] rdy, input logic [1:0] g);
      #1;
      check({tag, "_v"}, 128'(bus.link_v_o), 128'(v));
      if (v) check({tag, "_data"}, 128'(bus.link_data_o), 128'(d));
      check({tag, "_rdy"}, 128'(bus.ch_ready_and_o), 128'(rdy));
      check({tag, "_grant"}, 128'(bus.grant_o), 128'(g));
      tick();
   endtask

   task automatic set_ch(input int ch, input bit v, input logic [99:0] h, input logic [1:0] cid,
                         input logic [7:0] cord, input logic [2:0] beats, input logic [63:0] d);
      bus.ch_v_i[ch]                = v;
      bus.ch_hdr_i[ch*100 +: 100]   = h;
      bus.ch_dst_cid_i[ch*2 +: 2]   = cid;
      bus.ch_dst_cord_i[ch*8 +: 8]  = cord;
      bus.ch_beats_i[ch*3 +: 3]     = beats;
      bus.ch_data_i[ch*64 +: 64]    = d;
   endtask

   task automatic set_v(input int ch, input bit v);
      bus.ch_v_i[ch] = v;
   endtask

   task automatic set_d(input int ch, input logic [63:0] d);
      bus.ch_data_i[ch*64 +: 64] = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [99:0]  h0, h1, h2;
      logic [127:0] w;
      logic [63:0]  a0, a1, b0, b1, c0, c1;
      logic [63:0]  d0, d1, e0;

      h0 = 100'h123456789ABCDEF0123456789;
      h1 = 100'hFEDCBA9876543210FEDCBA987;
      h2 = 100'hABCDE;
      d0 = 64'hD000_0000_0000_0001;
      d1 = 64'hD111_1111_1111_1112;
      e0 = 64'hE0E0_E0E0_E0E0_E0E0;

      bus.ch_hdr_i = '0; bus.ch_dst_cord_i = '0; bus.ch_dst_cid_i = '0;
      bus.ch_beats_i = '0; bus.ch_data_i = '0; bus.ch_v_i = '0;
      bus.link_ready_and_i = 1'b1;
      reset_n_i = 1'b0;
      tick(); tick();
      cyc("rst", 0, '0, 2'b00, 2'b00);
      reset_n_i = 1'b1;

      // ch0, 2 beats, cord 0x05 -> len 3, flits on cycles 1..4.
      w = hw(h0, 2'd1, 4'd3, 8'h05); a0 = w[63:0]; a1 = w[127:64];
      set_ch(0, 1, h0, 2'd1, 8'h05, 3'd2, d0);
      cyc("t1c0", 0, '0, 2'b00, 2'b00);
      check("t1_cord", 128'(bus.link_data_o[7:0]), 128'(8'h05));
      check("t1_len", 128'(bus.link_data_o[11:8]), 128'(4'd3));
      cyc("t1c1", 1, a0, 2'b00, 2'b01);
      cyc("t1c2", 1, a1, 2'b00, 2'b01);
      cyc("t1c3", 1, d0, 2'b01, 2'b01);
      set_d(0, d1);
      cyc("t1c4", 1, d1, 2'b01, 2'b01);

      // ch0 header-only: beat consumed together with flit 1.
      w = hw(h2, 2'd2, 4'd1, 8'h33); b0 = w[63:0]; b1 = w[127:64];
      set_ch(0, 1, h2, 2'd2, 8'h33, 3'd0, e0);
      cyc("t2c0", 0, '0, 2'b00, 2'b00);
      cyc("t2c1", 1, b0, 2'b00, 2'b01);
      cyc("t2c2", 1, b1, 2'b01, 2'b01);

      // Both header-only; priority now at ch1 so ch1 goes first, then ch0.
      w = hw(h1, 2'd3, 4'd1, 8'hA7); c0 = w[63:0]; c1 = w[127:64];
      set_ch(1, 1, h1, 2'd3, 8'hA7, 3'd0, e0);
      set_ch(0, 1, h2, 2'd2, 8'h33, 3'd0, e0);
      cyc("t2c3", 0, '0, 2'b00, 2'b00);
      cyc("t2c4", 1, c0, 2'b00, 2'b10);
      cyc("t2c5", 1, c1, 2'b10, 2'b10);
      set_v(1, 0);
      cyc("t2c6", 0, '0, 2'b00, 2'b00);
      cyc("t2c7", 1, b0, 2'b00, 2'b01);
      cyc("t2c8", 1, b1, 2'b01, 2'b01);
      set_v(0, 0);
      cyc("t2c9", 0, '0, 2'b00, 2'b00);

      // After reset, simultaneous 1-beat requests: ch0 then ch1, no interleave.
      reset_n_i = 1'b0;
      cyc("t3rst", 0, '0, 2'b00, 2'b00);
      reset_n_i = 1'b1;
      w = hw(h0, 2'd1, 4'd2, 8'h05); a0 = w[63:0]; a1 = w[127:64];
      w = hw(h1, 2'd3, 4'd2, 8'hA7); c0 = w[63:0]; c1 = w[127:64];
      set_ch(0, 1, h0, 2'd1, 8'h05, 3'd1, d0);
      set_ch(1, 1, h1, 2'd3, 8'hA7, 3'd1, d1);
      cyc("t3c0", 0, '0, 2'b00, 2'b00);
      cyc("t3c1", 1, a0, 2'b00, 2'b01);
      cyc("t3c2", 1, a1, 2'b00, 2'b01);
      cyc("t3c3", 1, d0, 2'b01, 2'b01);
      set_v(0, 0);
      cyc("t3c4", 0, '0, 2'b00, 2'b00);
      cyc("t3c5", 1, c0, 2'b00, 2'b10);
      cyc("t3c6", 1, c1, 2'b00, 2'b10);
      cyc("t3c7", 1, d1, 2'b10, 2'b10);
      set_v(1, 0);
      cyc("t3c8", 0, '0, 2'b00, 2'b00);

      // Link stall on header flit 1, then on the data beat.
      set_ch(0, 1, h0, 2'd1, 8'h05, 3'd1, d0);
      cyc("t4c0", 0, '0, 2'b00, 2'b00);
      cyc("t4c1", 1, a0, 2'b00, 2'b01);
      bus.link_ready_and_i = 1'b0;
      cyc("t4c2", 1, a1, 2'b00, 2'b01);
      cyc("t4c3", 1, a1, 2'b00, 2'b01);
      cyc("t4c4", 1, a1, 2'b00, 2'b01);
      bus.link_ready_and_i = 1'b1;
      cyc("t4c5", 1, a1, 2'b00, 2'b01);
      bus.link_ready_and_i = 1'b0;
      cyc("t4c6", 1, d0, 2'b00, 2'b01);
      cyc("t4c7", 1, d0, 2'b00, 2'b01);
      bus.link_ready_and_i = 1'b1;
      cyc("t4c8", 1, d0, 2'b01, 2'b01);
      set_v(0, 0);
      cyc("t4c9", 0, '0, 2'b00, 2'b00);

      // ch0 valid gap mid-data while ch1 waits; ownership is kept.
      w = hw(h0, 2'd1, 4'd3, 8'h05); a0 = w[63:0]; a1 = w[127:64];
      w = hw(h1, 2'd3, 4'd1, 8'hA7); c0 = w[63:0]; c1 = w[127:64];
      set_ch(0, 1, h0, 2'd1, 8'h05, 3'd2, d0);
      cyc("t5c0", 0, '0, 2'b00, 2'b00);
      set_ch(1, 1, h1, 2'd3, 8'hA7, 3'd0, e0);
      cyc("t5c1", 1, a0, 2'b00, 2'b01);
      cyc("t5c2", 1, a1, 2'b00, 2'b01);
      cyc("t5c3", 1, d0, 2'b01, 2'b01);
      set_v(0, 0);
      cyc("t5c4", 0, '0, 2'b01, 2'b01);
      cyc("t5c5", 0, '0, 2'b01, 2'b01);
      set_v(0, 1); set_d(0, d1);
      cyc("t5c6", 1, d1, 2'b01, 2'b01);
      set_v(0, 0);
      cyc("t5c7", 0, '0, 2'b00, 2'b00);
      cyc("t5c8", 1, c0, 2'b00, 2'b10);
      cyc("t5c9", 1, c1, 2'b10, 2'b10);
      set_v(1, 0);
      cyc("t5c10", 0, '0, 2'b00, 2'b00);

      // Reset during e_data; afterwards ch0 beats ch1 despite the pointer having moved.
      set_ch(0, 1, h0, 2'd1, 8'h05, 3'd2, d0);
      cyc("t6c0", 0, '0, 2'b00, 2'b00);
      cyc("t6c1", 1, a0, 2'b00, 2'b01);
      cyc("t6c2", 1, a1, 2'b00, 2'b01);
      reset_n_i = 1'b0;
      set_ch(1, 1, h1, 2'd3, 8'hA7, 3'd0, e0);
      tick();
      cyc("t6c4", 0, '0, 2'b00, 2'b00);
      reset_n_i = 1'b1;
      cyc("t6c5", 0, '0, 2'b00, 2'b00);
      cyc("t6c6", 1, a0, 2'b00, 2'b01);
      bus.ch_v_i = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bp_me_stream_mux_to_wormhole.md
# bp_me_stream_mux_to_wormhole

Multi-channel successor to the single-channel stream-to-wormhole converter used in the tile network interfaces. It accepts `num_ch_p` independent BedRock-style stream channels, arbitrates round-robin at packet granularity, and serializes each winning packet onto one ready/valid wormhole link. This lets a tile share one coherence or memory NoC link between several protocol sources, for example an I/O CCE command path and a link-to-LCE request path. It sits between the protocol engines and the `bsg_ready_and_link_sif` output of a tile.

## Interface
- `num_ch_p`, 2: number of input stream channels (≥1).
- `flit_width_p`, 64: wormhole flit width; also the data beat width.
- `cord_width_p`, 8: destination coordinate width.
- `len_width_p`, 4: wormhole length-field width.
- `cid_width_p`, 2: destination concentrator-id width.
- `hdr_width_p`, 100: protocol header width.
- `beats_width_p`, 3: width of the per-packet data-beat count.
- `clk_i`  in  1  clock; all logic on its rising edge.
- `reset_n_i`  in  1  synchronous, active-low reset.
- `ch_hdr_i`  in  `num_ch_p*hdr_width_p`  per-channel header; held stable for the whole packet.
- `ch_dst_cord_i`  in  `num_ch_p*cord_width_p`  per-channel destination coordinate.
- `ch_dst_cid_i`  in  `num_ch_p*cid_width_p`  per-channel destination cid.
- `ch_beats_i`  in  `num_ch_p*beats_width_p`  data beats in the packet; 0 means header-only.
- `ch_data_i`  in  `num_ch_p*flit_width_p`  per-beat data.
- `ch_v_i`  in  `num_ch_p`  beat valid.
- `ch_ready_and_o`  out  `num_ch_p`  beat accept.
- `link_data_o`  out  `flit_width_p`  flit out.
- `link_v_o`  out  1  flit valid.
- `link_ready_and_i`  in  1  link accept.
- `grant_o`  out  `num_ch_p`  one-hot owner of the current packet; 0 when idle (debug/perf).

## Operation
- Header flit count is H = ceil((cord_width_p+len_width_p+cid_width_p+hdr_width_p)/flit_width_p). It is elaborated as a constant and must be ≥1.
- Wormhole header word is packed LSB-first as {hdr, cid, len, cord}. It is zero-padded to H*flit_width_p.
- len = H-1+beats. The elaboration-time check requires H-1+2^beats_width_p-1 < 2^len_width_p.
- FSM states are e_idle, e_hdr and e_data.
- e_idle:
  - Round-robin arbiter picks among `ch_v_i`. Priority starts at the channel after the last grant; after reset it starts at channel 0.
  - On a pick: latch the packed header word, beats and grant; clear the flit counter; go to e_hdr.
  - No channel is accepted in this state.
- e_hdr:
  - `link_v_o`=1 and `link_data_o` = latched header slice [cnt].
  - On each link handshake, cnt++.
  - On the handshake of flit H-1: if beats==0, assert `ch_ready_and_o[grant]` in that same cycle (header-only beat consumed) and go to e_idle. Otherwise go to e_data.
- e_data:
  - Pass-through: `link_v_o`=`ch_v_i[grant]`, `link_data_o`=`ch_data_i[grant]`, `ch_ready_and_o[grant]`=`link_ready_and_i`.
  - Each handshake decrements beats. The handshake at beats==1 returns the FSM to e_idle.
- Non-granted channels always see `ch_ready_and_o`=0.
- Source rule: once `ch_v_i` rises it is held until accepted, and header/dst/beats are stable until the last beat. Benches assert this.

## Timing
- Reset values: `link_v_o`=0, `ch_ready_and_o`=0, `grant_o`=0, FSM=e_idle, RR pointer=channel 0, counters=0.
- Latency:
  - One bubble cycle from a channel's valid to its first flit (the e_idle latch cycle).
  - Header flits then stream back-to-back under continuous `link_ready_and_i`.
  - Data beats add zero latency (combinational pass-through).
- There is no idle cycle between packets beyond the e_idle arbitration cycle. Peak throughput is (H+beats)/(H+beats+1).
- Link stall: the current flit is held and the counter does not advance.
- Data valid gap from the owning channel: `link_v_o` drops, wormhole ownership is retained, and no other channel is served.
- Simultaneous requests: exactly one grant per e_idle cycle. The loser is served next when still valid.
- Reset mid-packet: the FSM aborts to e_idle the next cycle and outputs return to reset values. The truncated packet is not completed; the downstream NoC is reset with it.

## Structure
- The packed wormhole header struct, the H computation macro and the FSM state enum belong in `bp_me_pkg` (`bp_me_wormhole_defines.svh`), shared with the single-channel converters.
- Natural sub-module: `bsg_arb_round_robin` for the grant, driven with `yumi` = e_idle & any valid.
- The header serializer is a counter-indexed mux with no separate module.

## Test plan
Defaults: num_ch_p=2, flit 64, hdr 100, so header bits = 114 and H=2.
- Reset, then ch0 beats=2, dst cord 0x05, ready held high → 4 flits on cycles 1–4. Flit0[7:0]=0x05, len=3, ch0 accepted on cycles 3–4.
- ch0 beats=0 → 2 header flits; `ch_ready_and_o[0]` pulses with flit 1; FSM is idle on the next cycle.
- ch0 and ch1 valid in the same cycle, beats=1 each → ch0 packet (3 flits), then ch1 packet, with no interleaving. Repeated simultaneous requests alternate ch1, ch0.
- `link_ready_and_i` low for 3 cycles during header flit 1 → flit 1 held constant and total length unchanged. Same stall during data → data held.
- ch0 drops valid for 2 cycles mid-data while ch1 is valid → `link_v_o`=0 for 2 cycles and ch1 is not granted until ch0's last beat.
- `reset_n_i` low during e_data → next cycle `link_v_o`=0 and `grant_o`=0. After release, ch0 wins priority over ch1.
